jk_bank_arbiter: RTL

- Round-robin arbiter and sequencer that shares one bank of WIDTH JK flip-flops among N_REQ requesters.
- Each requester submits a masked operation: read, clear, set or toggle.
- The block drives the bank's J/K vectors for exactly one cycle, then captures the updated Q back to the requester with a one-cycle grant pulse.
- It sits between requester logic and the JK flop bank. The bank shares clk and n_rst with this block.

---
 rtl/jk_bank_arbiter_pkg.sv | 21 ++
 rtl/jk_bank_arbiter_if.sv | 26 ++
 rtl/jk_bank_arbiter_rr_pick.sv | 29 ++
 rtl/jk_bank_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared encodings for the JK bank arbiter: op codes, FSM states, index width helper.
// Optional feature macro used by this slice: JKARB_LOCK_EN (requester lock / re-grant).
package jk_arb_pkg;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CAPT  = 2'b10,
        DONE  = 2'b11
    } state_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester/bank bundle for jk_bank_arbiter; master = requesters + flop bank, slave = arbiter.
// The lock vector exists only when JKARB_LOCK_EN is defined.
interface jk_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] mask;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       j;
    logic [WIDTH-1:0]       k;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       rdata;
    logic                   busy;
`ifdef JKARB_LOCK_EN
    logic [N_REQ-1:0]       lock;

    modport slave  (input  req, op, mask, q, lock, output j, k, gnt, rdata, busy);
    modport master (output req, op, mask, q, lock, input  j, k, gnt, rdata, busy);
`else
    modport slave  (input  req, op, mask, q, output j, k, gnt, rdata, busy);
    modport master (output req, op, mask, q, input  j, k, gnt, rdata, busy);
`endif

endinterface

// File: rtl/jk_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after rr_ptr_i, wrapping modulo N_REQ.
// Feature macro JKARB_LOCK_EN does not affect this block.
module rr_pick
    import jk_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    rr_ptr_i,
    output logic             valid_o,
    output logic [IW-1:0]    winner_o
);

    // Walk offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        for (int s = N_REQ; s >= 1; s--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i == ((int'(rr_ptr_i) + s) % N_REQ) && req_i[i]) begin
                    valid_o  = 1'b1;
                    winner_o = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin sequencer sharing one JK flop bank: IDLE -> DRIVE -> CAPT -> DONE per op.
// Define JKARB_LOCK_EN to add bus.lock, which lets the current winner keep priority.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    jk_bank_arbiter_if.slave bus
);

    localparam int            IW       = idx_w(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    winner_q, winner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] mask_sel;
    logic [N_REQ-1:0] win_onehot;
`ifdef JKARB_LOCK_EN
    logic             lock_sel;
`endif

    function automatic logic [2*WIDTH-1:0] jk_decode(input logic [1:0] opc,
                                                     input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] jk;
        case (opc)
            OP_CLR:  jk = {{WIDTH{1'b0}}, m};
            OP_SET:  jk = {m, {WIDTH{1'b0}}};
            OP_TGL:  jk = {m, m};
            default: jk = '0;
        endcase
        return jk;
    endfunction

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_vld),
        .winner_o (pick_idx)
    );

    always_comb begin
        op_sel     = OP_READ;
        mask_sel   = '0;
        win_onehot = '0;
`ifdef JKARB_LOCK_EN
        lock_sel   = 1'b0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                op_sel   = bus.op[2*i +: 2];
                mask_sel = bus.mask[WIDTH*i +: WIDTH];
            end
            win_onehot[i] = (winner_q == IW'(i));
`ifdef JKARB_LOCK_EN
            if (winner_q == IW'(i)) lock_sel = bus.lock[i];
`endif
        end
    end

    // J/K are computed at the arbitration edge so the registered drive is live for all of DRIVE.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_ptr_d = rr_ptr_q;
        j_d      = '0;
        k_d      = '0;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = DRIVE;
                    winner_d   = pick_idx;
                    {j_d, k_d} = jk_decode(op_sel, mask_sel);
                end
            end
            DRIVE: state_d = CAPT;
            CAPT: begin
                state_d  = DONE;
                rdata_d  = bus.q;
                gnt_d    = win_onehot;
                rr_ptr_d = winner_q;
            end
            DONE: begin
                state_d = IDLE;
`ifdef JKARB_LOCK_EN
                if (lock_sel)
                    rr_ptr_d = (winner_q == '0) ? LAST_IDX : winner_q - IW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            rr_ptr_q <= LAST_IDX;
            j_q      <= '0;
            k_q      <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            j_q      <= j_d;
            k_q      <= k_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
        end
    end

    assign bus.j     = j_q;
    assign bus.k     = k_q;
    assign bus.gnt   = gnt_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != IDLE);

endmodule
